qar_alu_regfile: RTL and testbench

- Execute datapath for the QAR-Core RV32I pipeline.
- Contains a 32x32 integer register file and a combinational ALU.
- The register file has two asynchronous read ports and one synchronous write port.
- The core's decode logic drives the register addresses, the ALU operands and the ALU op select. It routes alu_result back to rf_wdata for ADD/ADDI-style instructions.

---
 rtl/qar_alu_regfile_if.sv | 33 +++
 rtl/qar_alu_regfile.sv | 89 ++++++++
 tb/tb_qar_alu_regfile.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/qar_alu_regfile_if.sv
// qar_alu_regfile_if: register-file and ALU signal bundle between the decode
// logic (master) and the execute datapath (slave).
interface qar_alu_regfile_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [AW-1:0]   rf_raddr1;
    logic [AW-1:0]   rf_raddr2;
    logic [XLEN-1:0] rf_rdata1;
    logic [XLEN-1:0] rf_rdata2;
    logic [XLEN-1:0] alu_op_a;
    logic [XLEN-1:0] alu_op_b;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    // Decode side: drives addresses, write data and ALU controls.
    modport master (
        output rf_we, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2,
               alu_op_a, alu_op_b, alu_op,
        input  rf_rdata1, rf_rdata2, alu_result, alu_zero
    );

    // Datapath side: consumes controls, returns read data and ALU results.
    modport slave (
        input  rf_we, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2,
               alu_op_a, alu_op_b, alu_op,
        output rf_rdata1, rf_rdata2, alu_result, alu_zero
    );
endinterface

// File: rtl/qar_alu_regfile.sv
// qar_alu_regfile: RV32I execute datapath for QAR-Core.
// A 32x32 register file (two asynchronous reads, one synchronous write,
// x0 hardwired to zero) next to a purely combinational ALU.
module qar_alu_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input logic               clk,
    input logic               rst,
    qar_alu_regfile_if.slave  bus
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    logic [XLEN-1:0] regFile_q [NREGS];
    logic [XLEN-1:0] regFile_d [NREGS];

    logic [AW-1:0]   writeAddr;
    logic [AW-1:0]   readAddr1;
    logic [AW-1:0]   readAddr2;

    logic [XLEN-1:0] aluA;
    logic [XLEN-1:0] aluB;
    logic [4:0]      shiftAmount;
    logic [XLEN-1:0] aluResult;

    assign writeAddr   = bus.rf_waddr;
    assign readAddr1   = bus.rf_raddr1;
    assign readAddr2   = bus.rf_raddr2;
    assign aluA        = bus.alu_op_a;
    assign aluB        = bus.alu_op_b;
    // Only the low five bits of B select a shift distance.
    assign shiftAmount = aluB[4:0];

    // Next register-file contents: a write to any index except x0 replaces one entry.
    always_comb begin
        regFile_d = regFile_q;
        if (bus.rf_we && (writeAddr != '0)) begin
            regFile_d[writeAddr] = bus.rf_wdata;
        end
    end

    // Register-file storage; reset clears every entry and wins over a concurrent write.
    always_ff @(posedge clk) begin
        if (rst) begin
            regFile_q <= '{default: '0};
        end else begin
            regFile_q <= regFile_d;
        end
    end

    // Reads see the stored value (no write-through); x0 is forced to zero.
    assign bus.rf_rdata1 = (readAddr1 == '0) ? '0 : regFile_q[readAddr1];
    assign bus.rf_rdata2 = (readAddr2 == '0) ? '0 : regFile_q[readAddr2];

    // ALU operation select; unassigned encodings produce zero.
    always_comb begin
        aluResult = '0;
        case (bus.alu_op)
            ALU_ADD:  aluResult = aluA + aluB;
            ALU_SUB:  aluResult = aluA - aluB;
            ALU_AND:  aluResult = aluA & aluB;
            ALU_OR:   aluResult = aluA | aluB;
            ALU_XOR:  aluResult = aluA ^ aluB;
            ALU_SLL:  aluResult = aluA << shiftAmount;
            ALU_SRL:  aluResult = aluA >> shiftAmount;
            ALU_SRA:  aluResult = $unsigned($signed(aluA) >>> shiftAmount);
            ALU_SLT:  aluResult = {{(XLEN-1){1'b0}}, ($signed(aluA) < $signed(aluB))};
            ALU_SLTU: aluResult = {{(XLEN-1){1'b0}}, (aluA < aluB)};
            default:  aluResult = '0;
        endcase
    end

    assign bus.alu_result = aluResult;
    assign bus.alu_zero   = (aluResult == '0);

endmodule

// File: tb/tb_qar_alu_regfile.sv
// tb_qar_alu_regfile: self-checking bench for qar_alu_regfile.
// Table of ALU vectors, directed register-file sequences, and randomized
// ALU / register-file traffic against an abstract reference model.
module tb_qar_alu_regfile;

    logic clk;
    logic rst;

    qar_alu_regfile_if #(.XLEN(32), .AW(5)) bus ();

    qar_alu_regfile #(.XLEN(32), .NREGS(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checkCount;
    int errorCount;

    logic [31:0] regModel [32];

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expResult;
        logic        expZero;
    } aluVector_t;

    aluVector_t aluTable [$];

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU built from the operation definitions in plain arithmetic.
    function automatic logic [31:0] aluModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        int unsigned sh;
        logic [31:0] r;
        sa = a;
        sb = b;
        sh = b % 32;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << sh;
            4'd6: r = a >> sh;
            4'd7: begin
                r = a >> sh;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.alu_op   = op;
        bus.alu_op_a = a;
        bus.alu_op_b = b;
    endtask

    task automatic setWrite(input logic we, input logic [4:0] addr, input logic [31:0] data);
        bus.rf_we    = we;
        bus.rf_waddr = addr;
        bus.rf_wdata = data;
    endtask

    // Advance one clock edge, updating the model from the inputs held across it.
    task automatic stepClock();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) regModel[i] = 32'd0;
        end else if (bus.rf_we && bus.rf_waddr != 5'd0) begin
            regModel[bus.rf_waddr] = bus.rf_wdata;
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] modelRead(input logic [4:0] addr);
        return (addr == 5'd0) ? 32'd0 : regModel[addr];
    endfunction

    initial begin
        checkCount = 0;
        errorCount = 0;
        for (int i = 0; i < 32; i++) regModel[i] = 32'd0;

        aluTable.push_back('{"add_wrap",  4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1});
        aluTable.push_back('{"sub_under", 4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0});
        aluTable.push_back('{"sub_equal", 4'b0001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1});
        aluTable.push_back('{"and",       4'b0010, 32'hF0F0_000F, 32'h0000_FF24, 32'h0000_0004, 1'b0});
        aluTable.push_back('{"or",        4'b0011, 32'hF0F0_000F, 32'h0000_FF24, 32'hF0F0_FF2F, 1'b0});
        aluTable.push_back('{"xor",       4'b0100, 32'hF0F0_000F, 32'h0000_FF24, 32'hF0F0_FF2B, 1'b0});
        aluTable.push_back('{"sll",       4'b0101, 32'hF0F0_000F, 32'h0000_FF24, 32'h0F00_00F0, 1'b0});
        aluTable.push_back('{"srl",       4'b0110, 32'hF0F0_000F, 32'h0000_FF24, 32'h0F0F_0000, 1'b0});
        aluTable.push_back('{"sra",       4'b0111, 32'hF0F0_000F, 32'h0000_FF24, 32'hFF0F_0000, 1'b0});
        aluTable.push_back('{"slt",       4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0});
        aluTable.push_back('{"sltu",      4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1});
        aluTable.push_back('{"op_1111",   4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1});
        aluTable.push_back('{"op_1010",   4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
        aluTable.push_back('{"sra_pos",   4'b0111, 32'h7000_0000, 32'hFFFF_FFE4, 32'h0700_0000, 1'b0});
        aluTable.push_back('{"slt_false", 4'b1000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});

        // Reset held two cycles while a write to x5 is requested.
        rst            = 1'b1;
        bus.rf_raddr1  = 5'd0;
        bus.rf_raddr2  = 5'd0;
        setWrite(1'b1, 5'd5, 32'hDEAD_BEEF);
        applyStimulus(4'b0000, 32'd0, 32'd0);
        stepClock();
        stepClock();
        rst = 1'b0;
        setWrite(1'b0, 5'd0, 32'd0);

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            bus.rf_raddr1 = 5'(i);
            bus.rf_raddr2 = 5'(31 - i);
            #1;
            checkOutput($sformatf("reset_rd1_x%0d", i), bus.rf_rdata1, 32'd0);
            checkOutput($sformatf("reset_rd2_x%0d", 31 - i), bus.rf_rdata2, 32'd0);
        end

        // Table-driven ALU vectors.
        foreach (aluTable[k]) begin
            @(negedge clk);
            applyStimulus(aluTable[k].op, aluTable[k].a, aluTable[k].b);
            #1;
            checkOutput({"alu_", aluTable[k].name}, bus.alu_result, aluTable[k].expResult);
            checkOutput({"zero_", aluTable[k].name}, {31'd0, bus.alu_zero}, {31'd0, aluTable[k].expZero});
        end

        // Core program: x1 = 0+5, x2 = 0+3, x3 = x1+x2.
        @(negedge clk);
        applyStimulus(4'b0000, 32'd0, 32'd5);
        #1;
        checkOutput("prog_add_x1", bus.alu_result, 32'd5);
        setWrite(1'b1, 5'd1, bus.alu_result);
        stepClock();
        applyStimulus(4'b0000, 32'd0, 32'd3);
        #1;
        checkOutput("prog_add_x2", bus.alu_result, 32'd3);
        setWrite(1'b1, 5'd2, bus.alu_result);
        stepClock();
        setWrite(1'b0, 5'd0, 32'd0);
        bus.rf_raddr1 = 5'd1;
        bus.rf_raddr2 = 5'd2;
        #1;
        checkOutput("prog_read_x1", bus.rf_rdata1, 32'd5);
        checkOutput("prog_read_x2", bus.rf_rdata2, 32'd3);
        applyStimulus(4'b0000, bus.rf_rdata1, bus.rf_rdata2);
        #1;
        checkOutput("prog_sum", bus.alu_result, 32'd8);
        setWrite(1'b1, 5'd3, bus.alu_result);
        stepClock();
        setWrite(1'b0, 5'd0, 32'd0);
        bus.rf_raddr1 = 5'd3;
        bus.rf_raddr2 = 5'd3;
        #1;
        checkOutput("prog_x3_rd1", bus.rf_rdata1, 32'd8);
        checkOutput("prog_x3_rd2", bus.rf_rdata2, 32'd8);

        // Write to x0 is dropped.
        @(negedge clk);
        setWrite(1'b1, 5'd0, 32'h1234_5678);
        bus.rf_raddr1 = 5'd0;
        stepClock();
        setWrite(1'b0, 5'd0, 32'd0);
        #1;
        checkOutput("x0_after_write", bus.rf_rdata1, 32'd0);

        // Same-cycle read and write of x7: old value until the edge.
        bus.rf_raddr1 = 5'd7;
        setWrite(1'b1, 5'd7, 32'hA5A5_A5A5);
        #1;
        checkOutput("collide_before", bus.rf_rdata1, 32'd0);
        stepClock();
        setWrite(1'b0, 5'd0, 32'd0);
        #1;
        checkOutput("collide_after", bus.rf_rdata1, 32'hA5A5_A5A5);

        // Randomized ALU operations against the reference model.
        for (int n = 0; n < 200; n++) begin
            logic [3:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            logic [31:0] expR;
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            expR = aluModel(rop, ra, rb);
            @(negedge clk);
            applyStimulus(rop, ra, rb);
            #1;
            checkOutput($sformatf("rand_alu_op%0d_%0d", rop, n), bus.alu_result, expR);
            checkOutput($sformatf("rand_zero_op%0d_%0d", rop, n), {31'd0, bus.alu_zero}, {31'd0, (expR == 32'd0)});
        end

        // Randomized register-file traffic with occasional resets.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 59) == 0);
            setWrite(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom);
            bus.rf_raddr1 = 5'($urandom_range(0, 31));
            bus.rf_raddr2 = ($urandom_range(0, 4) == 0) ? bus.rf_raddr1 : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) bus.rf_raddr1 = bus.rf_waddr;
            #1;
            checkOutput($sformatf("rand_rd1_x%0d_%0d", bus.rf_raddr1, n), bus.rf_rdata1, modelRead(bus.rf_raddr1));
            checkOutput($sformatf("rand_rd2_x%0d_%0d", bus.rf_raddr2, n), bus.rf_rdata2, modelRead(bus.rf_raddr2));
            stepClock();
        end
        rst = 1'b0;
        setWrite(1'b0, 5'd0, 32'd0);

        // Final sweep of every register against the model.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            bus.rf_raddr1 = 5'(i);
            bus.rf_raddr2 = 5'(i);
            #1;
            checkOutput($sformatf("final_rd1_x%0d", i), bus.rf_rdata1, modelRead(5'(i)));
            checkOutput($sformatf("final_rd2_x%0d", i), bus.rf_rdata2, modelRead(5'(i)));
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
